spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
Command sequencer and register bank sitting behind the byte-level SPI slave receiver. It decodes the first byte of each SSEL-framed transaction as a command, then streams write data into, or read data out of, an auto-incrementing register bank. It supplies the next MISO byte to the transmitter and exposes the register bank to LED/GPIO logic in top.

Parameters:
ADDR_W, 3, register address width; NREGS = 2**ADDR_W registers of 8 bits each.
DEV_ID, 8'hA5, byte loaded for MISO at frame start; clocked out while the command byte is received.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst_n  in  1  asynchronous active-low reset.
frame_start  in  1  one-cycle pulse on SSEL falling edge, already synchronised to clk.
frame_end  in  1  one-cycle pulse on SSEL rising edge, already synchronised.
rx_valid  in  1  one-cycle pulse: a complete MOSI byte is on rx_data.
rx_data  in  8  received byte; valid only while rx_valid=1.
tx_data  out  8  next byte for the MISO shifter.
tx_load  out  1  one-cycle pulse: transmitter must latch tx_data.
regs_flat  out  NREGS*8  register bank; reg i occupies bits [8i+7:8i].
wr_strobe  out  1  one-cycle pulse on every accepted register write.
wr_addr  out  ADDR_W  address of the last accepted write.
busy  out  1  high when state is not IDLE.
cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all regs=0; addr=0; err_cnt=0; tx_data=8'h00; tx_load, wr_strobe, cmd_err, busy=0; wr_addr=0.
- Command byte format: bit7=1 means write, 0 means read; bits[ADDR_W-1:0] give the start address; bits[6:ADDR_W] are reserved and must be 0.
- Register NREGS-1 is read-only and returns err_cnt. Writes to it are dropped: no wr_strobe, but the address still advances.
- err_cnt is 8 bits and saturates at 8'hFF.
- States: IDLE, CMD, WRITE, READ, DISCARD.
- IDLE:
  - frame_start: go to CMD; the next cycle drives tx_data=DEV_ID with tx_load=1.
  - rx_valid and frame_end are ignored.
- CMD, on rx_valid:
  - Reserved bits nonzero: go to DISCARD; cmd_err=1 the next cycle; err_cnt+1; tx_data=8'hEE with tx_load=1.
  - Write command: addr is set from the command; go to WRITE.
  - Read command: addr is set from the command; go to READ; the next cycle drives tx_data=reg[addr] with tx_load=1. Latency is 1 clk.
- WRITE, on rx_valid:
  - reg[addr] is updated with rx_data at that edge, visible on regs_flat the next cycle.
  - wr_strobe=1 and wr_addr=addr, both registered.
  - addr advances to (addr+1) mod NREGS; wrap from NREGS-1 to 0 is required.
- READ, on rx_valid (dummy master byte):
  - addr advances to (addr+1) mod NREGS.
  - The next cycle drives tx_data = reg at the new addr, tx_load=1.
  - The read value is a snapshot at load time.
- DISCARD: all rx_valid pulses are ignored until frame_end.
- frame_end in any non-IDLE state: go to IDLE the next cycle. addr and regs are retained; tx_data is held.
- rx_valid and frame_end in the same cycle: the byte is processed first (the write or increment takes effect), then the state goes to IDLE.
- frame_start while not IDLE: the current frame is aborted; no error is counted; behave as frame_start from IDLE.
- frame_start and frame_end in the same cycle: frame_start wins.
- Asserting rst_n mid-frame: immediate return to reset values; the partial frame is lost.
- wr_strobe, tx_load and cmd_err are never high for more than 1 consecutive cycle per triggering event.

Test Plan:
- Reset, then frame_start → one cycle later tx_load=1, tx_data=8'hA5, busy=1.
- Write frame: cmd 8'h82, data 8'h11, 8'h22, then frame_end → reg2=8'h11, reg3=8'h22; two wr_strobe pulses with wr_addr=2, then 3; busy=0 after frame_end.
- Read wrap: preload reg6=8'h5A, reg0=8'h3C; cmd 8'h06 → tx 8'h5A; dummy byte → tx = err_cnt from reg7; dummy byte → tx 8'h3C (wrap to 0).
- Bad command 8'h48 → cmd_err pulse, tx_data=8'hEE; following data bytes leave regs unchanged; reg7 reads 1 in the next frame. Repeat 300 bad frames → reg7 reads 8'hFF.
- Write to reg7 (cmd 8'h87, data 8'h99) → no wr_strobe, reg7 unchanged; the next data byte lands in reg0.
- Simultaneous rx_valid+frame_end in WRITE → the byte is written and state=IDLE. frame_start mid-READ → tx_data=8'hA5 and a fresh CMD. rst_n pulse mid-write → all regs=0 immediately.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Command sequencer and register bank behind a byte-level SPI slave.
// The first byte of each SSEL frame is a command, followed by auto-incrementing writes or reads.
module spi_reg_ctrl #(
  parameter int         ADDR_W = 3,
  parameter logic [7:0] DEV_ID = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic                       frame_end,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic [7:0]                 tx_data,
  output logic                       tx_load,
  output logic [(2**ADDR_W)*8-1:0]   regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       busy,
  output logic                       cmd_err
);

  localparam int                NREGS   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] RO_ADDR = ADDR_W'(NREGS-1);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DISCARD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_inc, cmd_addr;
  // The top entry doubles as the saturating error counter; it is never written by the master.
  logic [7:0]        regs [NREGS];
  logic              cmd_bad, do_cmd, do_write, do_read;

  assign addr_inc = addr + ADDR_W'(1);
  assign cmd_addr = rx_data[ADDR_W-1:0];
  assign cmd_bad  = |rx_data[6:ADDR_W];

  // A new frame_start aborts whatever is in progress, so it masks the byte decode.
  assign do_cmd   = !frame_start && rx_valid && (state == CMD);
  assign do_write = !frame_start && rx_valid && (state == WRITE);
  assign do_read  = !frame_start && rx_valid && (state == READ);

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = CMD;
    end else begin
      if (do_cmd)
        state_nxt = cmd_bad ? DISCARD : (rx_data[7] ? WRITE : READ);
      // The byte arriving with frame_end is still processed above; then the frame closes.
      if (frame_end && (state != IDLE))
        state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      tx_data   <= 8'h00;
      tx_load   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      cmd_err   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      tx_load   <= 1'b0;
      wr_strobe <= 1'b0;
      cmd_err   <= 1'b0;

      if (frame_start) begin
        tx_data <= DEV_ID;
        tx_load <= 1'b1;
      end

      if (do_cmd) begin
        if (cmd_bad) begin
          cmd_err <= 1'b1;
          tx_data <= 8'hEE;
          tx_load <= 1'b1;
          if (regs[NREGS-1] != 8'hFF) regs[NREGS-1] <= regs[NREGS-1] + 8'd1;
        end else begin
          addr <= cmd_addr;
          if (!rx_data[7]) begin
            tx_data <= regs[cmd_addr];
            tx_load <= 1'b1;
          end
        end
      end

      if (do_write) begin
        if (addr != RO_ADDR) begin
          regs[addr] <= rx_data;
          wr_strobe  <= 1'b1;
          wr_addr    <= addr;
        end
        addr <= addr_inc;
      end

      // Read data is snapshotted at load time, one byte ahead of the master's dummy byte.
      if (do_read) begin
        addr    <= addr_inc;
        tx_data <= regs[addr_inc];
        tx_load <= 1'b1;
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) regs_flat[i*8 +: 8] = regs[i];
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: table of single-byte frames, then hand-written corner sequences.
// MISO loads and register write strobes are matched against expected queues by a monitor.
module tb_spi_reg_ctrl;

  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  frame_start = 1'b0;
  logic                  frame_end = 1'b0;
  logic                  rx_valid = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic [7:0]            tx_data;
  logic                  tx_load;
  logic [NREGS*8-1:0]    regs_flat;
  logic                  wr_strobe;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  busy;
  logic                  cmd_err;

  spi_reg_ctrl #(.ADDR_W(ADDR_W), .DEV_ID(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_data(tx_data), .tx_load(tx_load),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy),
    .cmd_err(cmd_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_cmd_err = 0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_wr_q[$];
  logic [7:0] exp_bank [NREGS-1];
  logic [7:0] exp_err;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_at(input int i);
    return regs_flat[i*8 +: 8];
  endfunction

  task automatic check_bank(input string tag);
    for (int j = 0; j < NREGS-1; j++) check8($sformatf("%s_reg%0d", tag, j), reg_at(j), exp_bank[j]);
    check8($sformatf("%s_reg7", tag), reg_at(7), exp_err);
  endtask

  // Monitor: outputs sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_load) begin
        if (exp_tx_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL tx_unexpected: got %02h expected no load", tx_data);
        end else begin
          check8("tx_data", tx_data, exp_tx_q.pop_front());
        end
      end
      if (wr_strobe) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL wr_unexpected: got addr %0d expected no strobe", wr_addr);
        end else begin
          check8("wr_addr", 8'(wr_addr), exp_wr_q.pop_front());
        end
      end
      if (cmd_err) n_cmd_err++;
    end
  end

  // Driver tasks: inputs change 1 ns after the rising edge, held for one cycle
  task automatic step_start();
    exp_tx_q.push_back(8'hA5);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic step_byte(input logic [7:0] b, input logic with_end);
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = b; frame_end = with_end;
    @(posedge clk); #1 rx_valid = 1'b0; rx_data = 8'($urandom); frame_end = 1'b0;
  endtask

  task automatic step_end();
    @(posedge clk); #1 frame_end = 1'b1;
    @(posedge clk); #1 frame_end = 1'b0;
  endtask

  task automatic expect_write(input int a, input logic [7:0] d);
    exp_wr_q.push_back(8'(a));
    exp_bank[a] = d;
  endtask

  // Table of one-command frames
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] data;
    logic       is_read;
    logic       exp_strobe;
    logic [7:0] exp_a;   // write: target address / read: first MISO byte
    logic [7:0] exp_b;   // write: register value afterwards / read: byte after the dummy
  } vec_t;

  localparam int NV = 9;
  vec_t       vecs [NV];
  vec_t       v;
  logic [7:0] c;

  initial begin
    vecs[0] = '{cmd: 8'h80, data: 8'hDE, is_read: 1'b0, exp_strobe: 1'b1, exp_a: 8'd0, exp_b: 8'hDE};
    vecs[1] = '{cmd: 8'h85, data: 8'h5C, is_read: 1'b0, exp_strobe: 1'b1, exp_a: 8'd5, exp_b: 8'h5C};
    vecs[2] = '{cmd: 8'h81, data: 8'h01, is_read: 1'b0, exp_strobe: 1'b1, exp_a: 8'd1, exp_b: 8'h01};
    vecs[3] = '{cmd: 8'h00, data: 8'hFF, is_read: 1'b1, exp_strobe: 1'b0, exp_a: 8'hDE, exp_b: 8'h01};
    vecs[4] = '{cmd: 8'h04, data: 8'h00, is_read: 1'b1, exp_strobe: 1'b0, exp_a: 8'h00, exp_b: 8'h5C};
    vecs[5] = '{cmd: 8'h86, data: 8'h33, is_read: 1'b0, exp_strobe: 1'b1, exp_a: 8'd6, exp_b: 8'h33};
    vecs[6] = '{cmd: 8'h05, data: 8'hA0, is_read: 1'b1, exp_strobe: 1'b0, exp_a: 8'h5C, exp_b: 8'h33};
    vecs[7] = '{cmd: 8'h87, data: 8'h99, is_read: 1'b0, exp_strobe: 1'b0, exp_a: 8'd7, exp_b: 8'h00};
    vecs[8] = '{cmd: 8'h07, data: 8'h12, is_read: 1'b1, exp_strobe: 1'b0, exp_a: 8'h00, exp_b: 8'hDE};

    for (int j = 0; j < NREGS-1; j++) exp_bank[j] = 8'h00;
    exp_err = 8'h00;

    // Reset values while rst_n is low
    #12;
    check8("rst_tx_data", tx_data, 8'h00);
    check8("rst_flags", {4'h0, tx_load, wr_strobe, cmd_err, busy}, 8'h00);
    check8("rst_wr_addr", 8'(wr_addr), 8'h00);
    check_bank("rst");
    #10 rst_n = 1'b1;

    // Frame start: DEV_ID is loaded and busy rises
    step_start();
    check8("start_busy", 8'(busy), 8'h01);
    step_end();
    check8("end_busy", 8'(busy), 8'h00);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      step_start();
      if (v.is_read) begin
        exp_tx_q.push_back(v.exp_a);
        step_byte(v.cmd, 1'b0);
        exp_tx_q.push_back(v.exp_b);
        step_byte(v.data, 1'b0);
        step_end();
      end else begin
        step_byte(v.cmd, 1'b0);
        if (v.exp_strobe) expect_write(int'(v.exp_a), v.exp_b);
        step_byte(v.data, 1'b0);
        step_end();
        check8($sformatf("vec%0d_reg", i), reg_at(int'(v.exp_a[2:0])), v.exp_b);
      end
    end

    // Two-byte write frame with auto-increment
    step_start();
    step_byte(8'h82, 1'b0);
    expect_write(2, 8'h11);
    step_byte(8'h11, 1'b0);
    expect_write(3, 8'h22);
    step_byte(8'h22, 1'b0);
    step_end();
    check8("burst_busy", 8'(busy), 8'h00);
    check_bank("burst");

    // Read across the read-only counter and wrap to address 0
    step_start(); step_byte(8'h86, 1'b0); expect_write(6, 8'h5A); step_byte(8'h5A, 1'b0); step_end();
    step_start(); step_byte(8'h80, 1'b0); expect_write(0, 8'h3C); step_byte(8'h3C, 1'b0); step_end();
    step_start();
    exp_tx_q.push_back(8'h5A); step_byte(8'h06, 1'b0);
    exp_tx_q.push_back(8'h00); step_byte(8'h00, 1'b0);
    exp_tx_q.push_back(8'h3C); step_byte(8'h00, 1'b0);
    step_end();

    // Rejected command: data bytes are ignored, counter increments
    step_start();
    exp_tx_q.push_back(8'hEE);
    step_byte(8'h48, 1'b0);
    step_byte(8'h12, 1'b0);
    step_byte(8'h34, 1'b0);
    step_end();
    exp_err = 8'h01;
    check_bank("bad1");
    check32("bad1_cmd_err", n_cmd_err, 1);
    step_start();
    exp_tx_q.push_back(8'h01); step_byte(8'h07, 1'b0);
    exp_tx_q.push_back(exp_bank[0]); step_byte(8'h00, 1'b0);
    step_end();

    // Error counter saturation under random rejected commands
    for (int k = 0; k < 300; k++) begin
      c = {1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 3'($urandom_range(0, 7))};
      step_start();
      exp_tx_q.push_back(8'hEE);
      step_byte(c, 1'b0);
      step_byte(8'($urandom), 1'b0);
      step_end();
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    end
    check_bank("sat");
    step_start();
    exp_tx_q.push_back(8'hFF); step_byte(8'h07, 1'b0);
    exp_tx_q.push_back(exp_bank[0]); step_byte(8'h00, 1'b0);
    step_end();

    // Write to the read-only register is dropped but the address still advances
    step_start();
    step_byte(8'h87, 1'b0);
    step_byte(8'h99, 1'b0);
    expect_write(0, 8'h55);
    step_byte(8'h55, 1'b0);
    step_end();
    check_bank("ro_wr");

    // Byte and frame_end in the same cycle
    step_start();
    step_byte(8'h84, 1'b0);
    expect_write(4, 8'h6B);
    step_byte(8'h6B, 1'b1);
    check8("same_cycle_busy", 8'(busy), 8'h00);
    check8("same_cycle_reg4", reg_at(4), 8'h6B);

    // frame_start in the middle of a read restarts with a fresh command
    step_start();
    exp_tx_q.push_back(exp_bank[1]);
    step_byte(8'h01, 1'b0);
    step_start();
    check8("restart_busy", 8'(busy), 8'h01);
    check8("restart_tx", tx_data, 8'hA5);
    step_byte(8'h83, 1'b0);
    expect_write(3, 8'h44);
    step_byte(8'h44, 1'b0);
    step_end();
    check_bank("restart");

    // Asynchronous reset in the middle of a write frame
    step_start();
    step_byte(8'h80, 1'b0);
    expect_write(0, 8'h7E);
    step_byte(8'h7E, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    for (int j = 0; j < NREGS-1; j++) exp_bank[j] = 8'h00;
    exp_err = 8'h00;
    check_bank("midrst");
    check8("midrst_tx", tx_data, 8'h00);
    check8("midrst_busy", 8'(busy), 8'h00);
    #5 rst_n = 1'b1;
    step_start();
    step_end();
    repeat (3) @(posedge clk);
    #1;

    check32("tx_q_drained", exp_tx_q.size(), 0);
    check32("wr_q_drained", exp_wr_q.size(), 0);
    check32("cmd_err_pulses", n_cmd_err, 301);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
